video_timing_gen: RTL and testbench
===================================

Name: video_timing_gen

Overview:
- Parameterised raster timing generator that sits directly upstream of the pixel-pattern logic and the three TMDS encoders in the HDMI output path.
- Produces the pixel coordinates (x, y) one pipeline ahead, for pixel generation.
- Produces de/hsync/vsync delayed by PIPE_DELAY, so they align with the registered colour data entering the encoders.
- Adds frame_start/line_start strobes and a global advance enable, normally driven by MMCM lock.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 1, asserted level of hsync/vsync (1 = active-high, as fed to encoder CD)
PIPE_DELAY, 1, cycles of delay from x/y to de/hsync/vsync/strobes (0..4)
CW, 10, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous reset, active-low
en  input  1  advance enable; counters and delay line move only when high
x  output  CW  current horizontal position, 0..H_TOTAL-1
y  output  CW  current vertical position, 0..V_TOTAL-1
de  output  1  display enable, delayed by PIPE_DELAY
hsync  output  1  horizontal sync, delayed, polarity SYNC_POL
vsync  output  1  vertical sync, delayed, polarity SYNC_POL
line_start  output  1  one-cycle pulse, delayed position x==0
frame_start  output  1  one-cycle pulse, delayed position x==0 and y==0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset applies on a clk edge with rst==0 and overrides en:
  - x=0, y=0.
  - Every delay stage is cleared: de=0, strobes=0, hsync/vsync = ~SYNC_POL.
- Reset mid-frame behaves identically; there is no partial-frame completion.
- x/y are registered:
  - On en, x increments; at x==H_TOTAL-1, x wraps to 0 and y advances.
  - y wraps from V_TOTAL-1 to 0.
  - With en==0, x, y and all delay stages hold.
- Stage-0 decode is combinational from x/y:
  - act = (x<H_ACTIVE)&&(y<V_ACTIVE).
  - hs = x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); vs changes on the line boundary, with x.
  - ls = (x==0).
  - fs = (x==0)&&(y==0).
- Delay line: PIPE_DELAY registered stages, advanced only on en.
  - Outputs: de=act, hsync=hs^~SYNC_POL, vsync=vs^~SYNC_POL.
  - line_start=ls&en and frame_start=fs&en, taken from the last stage.
  - PIPE_DELAY==0: outputs come directly from the stage-0 decode, unregistered.
- Because the stages hold during en==0, alignment with x/y is preserved across stalls. The strobes are gated by en, so a held strobe never repeats.
- Width rule: comparisons are unsigned at CW bits. Totals exceeding 2^CW are illegal; an elaboration-time check is required.
- First frame after reset:
  - Delay stages are reset to inactive, not back-filled.
  - The first PIPE_DELAY cycles therefore show de=0 and no strobe, even though x=0,y=0.

Test Plan:
- Defaults, rst low 4 cycles then high, en=1 -> x counts 0..799; y increments when x wraps 799->0; frame period 420000 cycles.
- Defaults, PIPE_DELAY=1 -> de first high 1 cycle after x==0, 640 cycles wide. hsync high exactly 96 cycles, starting 1 cycle after x==656. vsync high for 2 full lines, lines 490-491, delayed 1 cycle.
- Small config H=4/1/1/1, V=2/1/1/1, PIPE_DELAY=0 -> 7-cycle lines, 35-cycle frame. frame_start every 35 cycles; line_start every 7 cycles; de high 8 cycles per frame.
- Stall: en low for 5 cycles at x=100,y=10 -> x, y, de, hsync, vsync frozen; no strobes. Resume -> x=101 next edge, alignment unchanged.
- Reset mid-frame at x=700,y=300 -> next edge x=0,y=0, de=0, hsync/vsync inactive, no frame_start. After release, frame_start appears PIPE_DELAY cycles after the first en.
- SYNC_POL=0 -> hsync/vsync idle high, pulse low over the same windows as the defaults; reset value high.

Source files
------------

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered x/y counters plus a PIPE_DELAY-deep
// delay line that keeps de/sync/strobes aligned with downstream colour data.
module video_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b1,
  parameter int PIPE_DELAY = 1,
  parameter int CW         = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // One extra bit so window ends equal to 2**CW still compare correctly.
  localparam logic [CW:0] HA     = (CW+1)'(H_ACTIVE);
  localparam logic [CW:0] HS_BEG = (CW+1)'(H_ACTIVE + H_FP);
  localparam logic [CW:0] HS_END = (CW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW:0] VA     = (CW+1)'(V_ACTIVE);
  localparam logic [CW:0] VS_BEG = (CW+1)'(V_ACTIVE + V_FP);
  localparam logic [CW:0] VS_END = (CW+1)'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);

  generate
    if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cw
      $error("video_timing_gen: CW=%0d too narrow for H_TOTAL=%0d / V_TOTAL=%0d", CW, H_TOTAL, V_TOTAL);
    end
    if (PIPE_DELAY < 0 || PIPE_DELAY > 4) begin : g_bad_dly
      $error("video_timing_gen: PIPE_DELAY=%0d outside 0..4", PIPE_DELAY);
    end
  endgenerate

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } dec_t;

  dec_t dec0, dec_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == H_LAST) begin
        x <= '0;
        y <= (y == V_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  always_comb begin
    dec0     = '0;
    dec0.act = ({1'b0, x} < HA) && ({1'b0, y} < VA);
    dec0.hs  = ({1'b0, x} >= HS_BEG) && ({1'b0, x} < HS_END);
    dec0.vs  = ({1'b0, y} >= VS_BEG) && ({1'b0, y} < VS_END);
    dec0.ls  = (x == '0);
    dec0.fs  = (x == '0) && (y == '0);
  end

  generate
    if (PIPE_DELAY == 0) begin : g_nodly
      assign dec_q = dec0;
    end else begin : g_dly
      dec_t dly_pipe [PIPE_DELAY];

      // Stages freeze with x/y on en==0 and restart inactive after reset.
      always_ff @(posedge clk) begin
        if (!rst) begin
          for (int i = 0; i < PIPE_DELAY; i++) dly_pipe[i] <= '0;
        end else if (en) begin
          dly_pipe[0] <= dec0;
          for (int i = 1; i < PIPE_DELAY; i++) dly_pipe[i] <= dly_pipe[i-1];
        end
      end

      assign dec_q = dly_pipe[PIPE_DELAY-1];
    end
  endgenerate

  assign de          = dec_q.act;
  assign hsync       = dec_q.hs ^ ~SYNC_POL;
  assign vsync       = dec_q.vs ^ ~SYNC_POL;
  // Gated so a strobe held across a stall fires only once.
  assign line_start  = dec_q.ls & en;
  assign frame_start = dec_q.fs & en;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: three generator configs checked every cycle against a
// pixel-index model, plus directed width/period/stall/reset checks.
module tb_video_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic de;
    logic hs;
    logic vs;
    logic ls;
    logic fs;
  } obs_t;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, d;
    bit pol;
  } cfg_t;

  typedef struct {
    obs_t a, b, c;
  } exp3_t;

  logic clk, rst, en;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic de_a, hs_a, vs_a, ls_a, fs_a;
  logic de_b, hs_b, vs_b, ls_b, fs_b;
  logic de_c, hs_c, vs_c, ls_c, fs_c;

  // A: default horizontal, short vertical; B: tiny raster, no delay;
  // C: default horizontal, active-low syncs, two-stage delay.
  video_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1),
    .PIPE_DELAY(1), .CW(10)) u_a (
    .clk(clk), .rst(rst), .en(en), .x(x_a), .y(y_a), .de(de_a), .hsync(hs_a),
    .vsync(vs_a), .line_start(ls_a), .frame_start(fs_a));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1),
    .PIPE_DELAY(0), .CW(10)) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x_b), .y(y_b), .de(de_b), .hsync(hs_b),
    .vsync(vs_b), .line_start(ls_b), .frame_start(fs_b));

  video_timing_gen #(.H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b0),
    .PIPE_DELAY(2), .CW(10)) u_c (
    .clk(clk), .rst(rst), .en(en), .x(x_c), .y(y_c), .de(de_c), .hsync(hs_c),
    .vsync(vs_c), .line_start(ls_c), .frame_start(fs_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cfg_t  cfg [3];
  int    pix [3];
  int    adv [3];
  exp3_t sb [$];
  int    nvec, nmis, cyc;
  bit    meas;

  bit phs, pde, pvs, hs_on, de_on, vs_on;
  int hrun, derun, vrun, lastfs, lastls, debcnt;

  function automatic obs_t predict(input cfg_t c, input int p, input int a, input bit e);
    int ht, vt, fr, q, qx, qy;
    bit hr, vr;
    obs_t o;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    fr = ht * vt;
    o = '0;
    o.x = 10'(p % ht);
    o.y = 10'(p / ht);
    hr = 1'b0;
    vr = 1'b0;
    if (a >= c.d) begin
      q  = (p - c.d + fr) % fr;
      qx = q % ht;
      qy = q / ht;
      o.de = (qx < c.ha) && (qy < c.va);
      hr   = (qx >= c.ha + c.hf) && (qx < c.ha + c.hf + c.hs);
      vr   = (qy >= c.va + c.vf) && (qy < c.va + c.vf + c.vs);
      o.ls = (qx == 0) && e;
      o.fs = (q == 0) && e;
    end
    o.hs = c.pol ? hr : !hr;
    o.vs = c.pol ? vr : !vr;
    return o;
  endfunction

  task automatic cmp(input string tag, input obs_t o, input obs_t e);
    nvec++;
    assert (o === e) else begin
      nmis++;
      $error("FAIL %s cyc %0d: observed x=%0d y=%0d de/hs/vs/ls/fs=%b%b%b%b%b, expected x=%0d y=%0d de/hs/vs/ls/fs=%b%b%b%b%b",
        tag, cyc, o.x, o.y, o.de, o.hs, o.vs, o.ls, o.fs, e.x, e.y, e.de, e.hs, e.vs, e.ls, e.fs);
    end
  endtask

  task automatic chk(input string tag, input int o, input int e);
    nvec++;
    assert (o === e) else begin
      nmis++;
      $error("FAIL %s cyc %0d: observed %0d, expected %0d", tag, cyc, o, e);
    end
  endtask

  task automatic track();
    if (hs_a) begin
      if (!phs) begin hs_on = meas; hrun = 0; if (meas) chk("A hsync rise x", x_a, 657); end
      hrun++;
    end else if (phs && hs_on && meas) chk("A hsync width", hrun, 96);
    if (de_a) begin
      if (!pde) begin de_on = meas; derun = 0; if (meas) chk("A de rise x", x_a, 1); end
      derun++;
    end else if (pde && de_on && meas) chk("A de width", derun, 640);
    if (vs_a) begin
      if (!pvs) begin vs_on = meas; vrun = 0; if (meas) chk("A vsync rise y", y_a, 22); end
      vrun++;
    end else if (pvs && vs_on && meas) chk("A vsync width", vrun, 1600);
    phs = hs_a; pde = de_a; pvs = vs_a;
    if (ls_b) begin
      if (meas && lastls >= 0) chk("B line period", cyc - lastls, 7);
      lastls = cyc;
    end
    if (fs_b) begin
      if (meas && lastfs >= 0) begin
        chk("B frame period", cyc - lastfs, 35);
        chk("B de per frame", debcnt, 8);
      end
      lastfs = cyc;
      debcnt = 0;
    end
    if (de_b) debcnt++;
  endtask

  // Drive one edge's inputs, predict its outcome, then compare after it.
  task automatic step(input bit r, input bit e);
    exp3_t ex;
    rst = r;
    en  = e;
    for (int i = 0; i < 3; i++) begin
      if (!r) begin
        pix[i] = 0;
        adv[i] = 0;
      end else if (e) begin
        pix[i] = (pix[i] + 1) % ((cfg[i].ha + cfg[i].hf + cfg[i].hs + cfg[i].hb) *
                                 (cfg[i].va + cfg[i].vf + cfg[i].vs + cfg[i].vb));
        adv[i]++;
      end
    end
    ex.a = predict(cfg[0], pix[0], adv[0], e);
    ex.b = predict(cfg[1], pix[1], adv[1], e);
    ex.c = predict(cfg[2], pix[2], adv[2], e);
    sb.push_back(ex);
    @(negedge clk);
    cyc++;
    ex = sb.pop_front();
    cmp("A", {x_a, y_a, de_a, hs_a, vs_a, ls_a, fs_a}, ex.a);
    cmp("B", {x_b, y_b, de_b, hs_b, vs_b, ls_b, fs_b}, ex.b);
    cmp("C", {x_c, y_c, de_c, hs_c, vs_c, ls_c, fs_c}, ex.c);
    track();
  endtask

  initial begin
    nvec = 0; nmis = 0; cyc = 0; meas = 1'b0;
    phs = 0; pde = 0; pvs = 0; hs_on = 0; de_on = 0; vs_on = 0;
    hrun = 0; derun = 0; vrun = 0; lastfs = -1; lastls = -1; debcnt = 0;
    cfg[0] = '{640, 16, 96, 48, 20, 2, 2, 3, 1, 1'b1};
    cfg[1] = '{4, 1, 1, 1, 2, 1, 1, 1, 0, 1'b1};
    cfg[2] = '{640, 16, 96, 48, 20, 2, 2, 3, 2, 1'b0};
    for (int i = 0; i < 3; i++) begin pix[i] = 0; adv[i] = 0; end
    rst = 1'b0;
    en  = 1'b0;
    @(negedge clk);

    // Reset held four cycles with en high: reset must win.
    repeat (4) step(1'b0, 1'b1);
    chk("A reset x", x_a, 0);
    chk("A reset y", y_a, 0);
    chk("A reset de", de_a, 0);
    chk("A reset hsync", hs_a, 0);
    chk("A reset frame_start", fs_a, 0);
    chk("C reset hsync idle high", hs_c, 1);
    chk("C reset vsync idle high", vs_c, 1);

    meas = 1'b1;
    while (pix[0] != 10 * 800 + 100 && cyc < 60000) step(1'b1, 1'b1);
    chk("A pre-stall x", x_a, 100);
    chk("A pre-stall y", y_a, 10);

    meas = 1'b0;
    repeat (5) begin
      step(1'b1, 1'b0);
      chk("A stall x", x_a, 100);
      chk("A stall y", y_a, 10);
      chk("A stall de", de_a, 1);
      chk("stall strobes", {ls_a, fs_a, ls_b, fs_b, ls_c, fs_c}, 0);
    end
    step(1'b1, 1'b1);
    chk("A resume x", x_a, 101);
    chk("A resume y", y_a, 10);

    hs_on = 0; de_on = 0; vs_on = 0; lastfs = -1; lastls = -1;
    meas = 1'b1;
    while (pix[0] != 25 * 800 + 700 && cyc < 60000) step(1'b1, 1'b1);
    chk("A pre-reset y", y_a, 25);
    meas = 1'b0;

    // Mid-frame reset with en high, then release with en low for a while.
    step(1'b0, 1'b1);
    chk("A midreset x", x_a, 0);
    chk("A midreset y", y_a, 0);
    chk("A midreset de", de_a, 0);
    chk("A midreset vsync", vs_a, 0);
    chk("A midreset frame_start", fs_a, 0);
    chk("C midreset hsync", hs_c, 1);
    chk("C midreset vsync", vs_c, 1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("A released idle x", x_a, 0);
    step(1'b1, 1'b1);
    chk("A frame_start after 1st en", fs_a, 1);
    chk("C frame_start after 1st en", fs_c, 0);
    step(1'b1, 1'b1);
    chk("A frame_start after 2nd en", fs_a, 0);
    chk("C frame_start after 2nd en", fs_c, 1);
    repeat (100) step(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
